systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder_pkg.sv | 19 +
 rtl/skew_line.sv | 31 +++
 rtl/systolic_feeder.sv | 120 ++++++++++++
 tb/tb_systolic_feeder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic array operand feeder: scalar width, lane count,
// the valid-tagged Scalar struct and the feeder FSM state encoding.
package systolic_feeder_pkg;

    localparam int SINGLE        = 32;
    localparam int SYS_ARRAY_LEN = 4;

    typedef struct packed {
        logic [SINGLE-1:0] value;
        logic              valid;
    } scalar_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage Scalar shift register with synchronous active-low clear; one per
// feeder lane, so lane i of the array sees its data i cycles after lane 0.
module skew_line
    import systolic_feeder_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  scalar_t feed,
    output scalar_t tap
);

    scalar_t stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            stage_reg[0] <= feed;
            for (int k = 1; k < DEPTH; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign tap = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews one k-step of A/B operands per handshake into the systolic array's
// row/column Scalar inputs. Optional per-pass beat counter: FEEDER_BEAT_CNT_EN.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int LEN = SYS_ARRAY_LEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LEN-1:0][SINGLE-1:0]  a_vec,
    input  logic [LEN-1:0][SINGLE-1:0]  b_vec,
    input  logic                        in_last,
    output scalar_t [LEN-1:0]           row,
    output scalar_t [LEN-1:0]           column,
    output logic                        busy,
    output logic                        done
`ifdef FEEDER_BEAT_CNT_EN
    ,
    output logic [15:0]                 beat_cnt
`endif
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    feeder_state_t    state_reg;
    logic [CNT_W-1:0] drain_reg;
    logic             done_reg;
    logic             accept;

    assign in_ready = (state_reg != DRAIN);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign accept   = in_valid && in_ready;

    // The drain count covers the extra cycles lane LEN-1 needs to present the
    // final beat; done is raised on the edge that makes that beat visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            drain_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (in_last) begin
                            if (LEN == 1) begin
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= DRAIN;
                                drain_reg <= CNT_W'(LEN - 1);
                            end
                        end else begin
                            state_reg <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    drain_reg <= drain_reg - 1'b1;
                    if (drain_reg == CNT_W'(1)) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_lane
            scalar_t row_feed;
            scalar_t col_feed;

            // Cycles without an accepted beat inject an all-zero bubble.
            assign row_feed.value = accept ? a_vec[gi] : '0;
            assign row_feed.valid = accept;
            assign col_feed.value = accept ? b_vec[gi] : '0;
            assign col_feed.valid = accept;

            skew_line #(.DEPTH(gi + 1)) u_row (
                .clk   (clk),
                .rst_n (rst_n),
                .feed  (row_feed),
                .tap   (row[gi])
            );

            skew_line #(.DEPTH(gi + 1)) u_col (
                .clk   (clk),
                .rst_n (rst_n),
                .feed  (col_feed),
                .tap   (column[gi])
            );
        end
    endgenerate

`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0] beat_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            if (state_reg == IDLE) begin
                beat_cnt_reg <= 16'd1;
            end else if (beat_cnt_reg != 16'hFFFF) begin
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
        end
    end

    assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (LEN=4); beat_cnt checks are active when
// FEEDER_BEAT_CNT_EN is defined for both the bench and the design.
module tb_systolic_feeder;
    import systolic_feeder_pkg::*;

    localparam int LEN = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [LEN-1:0][SINGLE-1:0] a_vec;
    logic [LEN-1:0][SINGLE-1:0] b_vec;
    logic                       in_last;
    scalar_t [LEN-1:0]          row;
    scalar_t [LEN-1:0]          column;
    logic                       busy;
    logic                       done;
`ifdef FEEDER_BEAT_CNT_EN
    logic [15:0]                beat_cnt;
`endif

    systolic_feeder #(.LEN(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .in_last  (in_last),
        .row      (row),
        .column   (column),
        .busy     (busy),
        .done     (done)
`ifdef FEEDER_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
    } sb_entry_t;

    sb_entry_t sb[$];
    int  cyc        = 0;
    int  ready_at   = 0;
    int  done_cyc   = -1;
    bit  in_stream  = 0;
    bit  last_acc   = 0;
    int  beat_model = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;

    // Advance one clock: update the reference model at the edge, then compare
    // every lane and status output against the scoreboard on the falling edge.
    task automatic tick();
        bit      acc;
        bit      lst;
        scalar_t exp_r;
        scalar_t exp_c;
        acc = rst_n && in_valid && (cyc >= ready_at);
        lst = in_last;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (!rst_n) begin
            sb.delete();
            ready_at   = cyc;
            in_stream  = 0;
            done_cyc   = -1;
            beat_model = 0;
        end else if (acc) begin
            for (int i = 0; i < LEN; i++) begin
                sb.push_back('{cyc: cyc + i, lane: i, a: a_vec[i], b: b_vec[i]});
            end
            beat_model = in_stream ? ((beat_model == 65535) ? 65535 : beat_model + 1) : 1;
            $display("beat cycle=%0d a0=%h b0=%h last=%0b", cyc, a_vec[0], b_vec[0], lst);
            if (lst) begin
                done_cyc  = cyc + LEN - 1;
                ready_at  = cyc + LEN - 1;
                in_stream = 0;
            end else begin
                in_stream = 1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < LEN; i++) begin
            exp_r = '0;
            exp_c = '0;
            for (int k = 0; k < sb.size(); k++) begin
                if (sb[k].cyc == cyc && sb[k].lane == i) begin
                    exp_r = '{value: sb[k].a, valid: 1'b1};
                    exp_c = '{value: sb[k].b, valid: 1'b1};
                    sb.delete(k);
                    break;
                end
            end
            n_checks++;
            if (row[i] !== exp_r) begin
                n_fail++;
                $display("FAIL row[%0d] cycle %0d: got %h/%b expected %h/%b",
                         i, cyc, row[i].value, row[i].valid, exp_r.value, exp_r.valid);
            end
            n_checks++;
            if (column[i] !== exp_c) begin
                n_fail++;
                $display("FAIL column[%0d] cycle %0d: got %h/%b expected %h/%b",
                         i, cyc, column[i].value, column[i].valid, exp_c.value, exp_c.valid);
            end
        end
        n_checks++;
        if (in_ready !== (cyc >= ready_at)) begin
            n_fail++;
            $display("FAIL in_ready cycle %0d: got %b expected %b", cyc, in_ready, cyc >= ready_at);
        end
        n_checks++;
        if (busy !== (in_stream || cyc < ready_at)) begin
            n_fail++;
            $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, in_stream || cyc < ready_at);
        end
        n_checks++;
        if (done !== (cyc == done_cyc)) begin
            n_fail++;
            $display("FAIL done cycle %0d: got %b expected %b", cyc, done, cyc == done_cyc);
        end
`ifdef FEEDER_BEAT_CNT_EN
        n_checks++;
        if (beat_cnt !== 16'(beat_model)) begin
            n_fail++;
            $display("FAIL beat_cnt cycle %0d: got %0d expected %0d", cyc, beat_cnt, beat_model);
        end
`endif
    endtask

    task automatic drive_beat(input logic [31:0] a0, input logic [31:0] b0, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < LEN; i++) begin
            a_vec[i] = a0 + 32'(i) * 32'h0080_0000;
            b_vec[i] = b0 + 32'(i) * 32'h0001_0000;
        end
    endtask

    task automatic idle_ticks(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        idle_ticks(2);
        for (int i = 0; i < LEN; i++) begin
            n_checks++;
            if (row[i] !== '0 || column[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_lane[%0d]: got %h %h expected 0 0", i, row[i], column[i]);
            end
        end
        n_checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_status: got ready/busy/done=%b expected 100", {in_ready, busy, done});
        end
`ifdef FEEDER_BEAT_CNT_EN
        n_checks++;
        if (beat_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt);
        end
`endif
    endtask

    task automatic test_single_beat();
        int done_at = -1;
        int not_ready = 0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        a_vec[0] = 32'h3F80_0000; a_vec[1] = 32'h4000_0000;
        a_vec[2] = 32'h4040_0000; a_vec[3] = 32'h4080_0000;
        b_vec[0] = 32'h40A0_0000; b_vec[1] = 32'h40C0_0000;
        b_vec[2] = 32'h40E0_0000; b_vec[3] = 32'h4100_0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (done && done_at < 0) done_at = k;
            if (!in_ready) not_ready++;
        end
        n_checks++;
        if (done_at !== LEN - 1) begin
            n_fail++;
            $display("FAIL single_done_latency: got %0d expected %0d", done_at, LEN - 1);
        end
        n_checks++;
        if (not_ready !== LEN - 1) begin
            n_fail++;
            $display("FAIL single_drain_cycles: got %0d expected %0d", not_ready, LEN - 1);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] v0 = '0;
        logic [7:0] v3 = '0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: drive_beat(32'h3F80_0000, 32'h40A0_0000, 1'b0);
                1: in_valid = 1'b0;
                2: drive_beat(32'h4110_0000, 32'h4120_0000, 1'b0);
                3: drive_beat(32'h4130_0000, 32'h4140_0000, 1'b1);
                default: begin in_valid = 1'b0; in_last = 1'b0; end
            endcase
            tick();
            v0[k] = row[0].valid;
            v3[k] = row[LEN-1].valid;
            if (k == 0) begin
                n_checks++;
                if (column[0].value !== 32'h40A0_0000) begin
                    n_fail++;
                    $display("FAIL bubble_bit_exact: got %h expected 40a00000", column[0].value);
                end
            end
        end
        n_checks++;
        if (v0 !== 8'b0000_1101) begin
            n_fail++;
            $display("FAIL bubble_lane0_pattern: got %b expected 00001101", v0);
        end
        n_checks++;
        if (v3 !== 8'b0110_1000) begin
            n_fail++;
            $display("FAIL bubble_lane3_pattern: got %b expected 01101000", v3);
        end
        idle_ticks(2);
    endtask

    task automatic test_drain_hold();
        int  waited = 0;
        bit  taken  = 0;
        int  a3_cyc = -1;
        int  b0_cyc = -1;
        drive_beat(32'h4150_0000, 32'h4160_0000, 1'b1);
        tick();
        drive_beat(32'h4170_0000, 32'h4180_0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!taken && last_acc) taken = 1;
            else if (!taken) waited++;
            if (taken) in_valid = 1'b0;
            if (row[LEN-1].valid && row[LEN-1].value === 32'h4150_0000 + 32'((LEN-1) * 32'h0080_0000))
                a3_cyc = cyc;
            if (row[0].valid && row[0].value === 32'h4170_0000 && b0_cyc < 0)
                b0_cyc = cyc;
        end
        n_checks++;
        if (!taken || waited !== LEN - 1) begin
            n_fail++;
            $display("FAIL drain_hold_wait: got taken=%0b waited=%0d expected 1/%0d", taken, waited, LEN - 1);
        end
        n_checks++;
        if (a3_cyc < 0 || b0_cyc - a3_cyc !== 1) begin
            n_fail++;
            $display("FAIL drain_no_overlap: got a3=%0d b0=%0d expected gap 1", a3_cyc, b0_cyc);
        end
        idle_ticks(2);
    endtask

    task automatic test_reset_mid_pass();
        int dones = 0;
        drive_beat(32'h4190_0000, 32'h41A0_0000, 1'b0);
        tick();
        drive_beat(32'h41B0_0000, 32'h41C0_0000, 1'b0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        n_checks++;
        if (row !== '0 || column !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midpass_flush: got row=%h col=%h busy=%b expected all 0", row, column, busy);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle_ticks(1);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midpass_done: got %0d pulses expected 0", dones);
        end
        test_single_beat();
    endtask

`ifdef FEEDER_BEAT_CNT_EN
    task automatic test_beat_cnt();
        for (int k = 1; k <= 5; k++) begin
            drive_beat(32'h3F00_0000 + 32'(k), 32'h3E00_0000 + 32'(k), k == 5);
            tick();
            n_checks++;
            if (beat_cnt !== 16'(k)) begin
                n_fail++;
                $display("FAIL beat_cnt_step: got %0d expected %0d", beat_cnt, k);
            end
        end
        idle_ticks(LEN + 2);
        n_checks++;
        if (beat_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL beat_cnt_hold: got %0d expected 5", beat_cnt);
        end
        drive_beat(32'h3D00_0000, 32'h3C00_0000, 1'b1);
        tick();
        n_checks++;
        if (beat_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL beat_cnt_restart: got %0d expected 1", beat_cnt);
        end
        idle_ticks(LEN + 1);
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_bubbles();
        test_drain_hold();
        test_reset_mid_pass();
`ifdef FEEDER_BEAT_CNT_EN
        test_beat_cnt();
`endif
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
